// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM data-memory controller.
//   mem_state_e        : FSM state encoding (IDLE=0, LOW=1, HIGH=2, DONE=3)
//   ADDR_BASE_DEFAULT  : byte address that maps to SRAM word 0
//   DQ_W               : SRAM data bus width in bits
package sram_mem_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  localparam int unsigned ADDR_BASE_DEFAULT = 1024;
  localparam int unsigned DQ_W              = 16;

endpackage

// File: rtl/sram_mem_controller.sv
// MEM-stage controller for an external 16-bit SRAM. A 32-bit word access
// (LDR/STR) is split into a low and a high half-word phase, each holding
// address/control on the SRAM for WAIT_CYCLES cycles, while ready=0 freezes
// the pipeline.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   rd_en, wr_en           MEM-stage mem_read / mem_write requests
//   address, write_data    byte address and store data (latched at start)
//   read_data              loaded word, valid from the cycle ready rises
//   ready                  1 = idle or completing, 0 = freeze the pipeline
//   sram_addr              half-word SRAM address (registered)
//   sram_dq_out/_oe/_in    SRAM data bus pieces; the tristate lives above
//   sram_we_n              SRAM write enable, active low (registered)
//   dbg_state              current FSM state, for observation only
//
// Handshake: a request is rd_en or wr_en held high. The controller samples it
// in IDLE; from then ready stays low until the DONE cycle, where ready=1
// means the access completes on the next rising edge. The requester keeps
// rd_en/wr_en asserted while ready=0 and may change them only after an edge
// with ready=1. Request inputs are ignored outside IDLE.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DQ_W-1:0]    sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [DQ_W-1:0]    sram_dq_in,
  output logic               sram_we_n,
  output mem_state_e         dbg_state
);

  localparam int unsigned     CNT_W       = $clog2(WAIT_CYCLES + 1);
  localparam int unsigned     WORD_W      = SRAM_AW - 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [31:0]     BASE        = 32'(ADDR_BASE);
  localparam bit              SINGLE_WAIT = (WAIT_CYCLES == 1);

  mem_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_rd_q, op_rd_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        read_data_q, read_data_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [DQ_W-1:0]    dq_out_q, dq_out_d;
  logic               dq_oe_q, dq_oe_d;
  logic               we_n_q, we_n_d;

  logic [WORD_W-1:0]  word_idx;
  logic               last_cnt;
  logic               in_phase_d;

  // Offset is taken modulo 2^32 so addresses below the base wrap around;
  // the byte offset bits [1:0] drop out with the shift.
  assign word_idx = WORD_W'((address - BASE) >> 2);
  assign last_cnt = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_rd_d     = op_rd_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rd_en || wr_en) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          op_rd_d = rd_en;  // both set is a protocol error; treated as read
          word_d  = word_idx;
          wdata_d = write_data;
        end
      end
      ST_LOW: begin
        if (last_cnt) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          if (op_rd_q) read_data_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (last_cnt) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          if (op_rd_q) read_data_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pin outputs are registered from the next state so they line up with it.
    in_phase_d  = (state_d == ST_LOW) || (state_d == ST_HIGH);
    sram_addr_d = in_phase_d ? {word_d, (state_d == ST_HIGH)} : sram_addr_q;
    dq_oe_d     = in_phase_d && !op_rd_d;
    dq_out_d    = dq_out_q;
    if (dq_oe_d) dq_out_d = (state_d == ST_HIGH) ? wdata_d[31:16] : wdata_d[15:0];
    // we_n rises on the last cycle of each phase so the SRAM latches on that
    // rising edge; with one wait cycle it stays low for the whole phase.
    we_n_d = !(dq_oe_d && (SINGLE_WAIT || (cnt_d != CNT_LAST)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_rd_q     <= 1'b1;
      word_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_rd_q     <= op_rd_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
    end
  end

  // Freeze must assert in the same cycle the request appears.
  assign ready       = ((state_q == ST_IDLE) && !rd_en && !wr_en) || (state_q == ST_DONE);
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign dbg_state   = state_q;

  a_no_rd_wr_together : assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == ST_IDLE) && rd_en && wr_en))
    else $error("rd_en and wr_en asserted together");

endmodule
